// File: rtl/osiris_pkg.sv
// Shared execute-stage definitions: RV32M funct3 codes and the muldiv FSM encoding.
package osiris_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/adder.sv
// Plain ripple-style adder with carry-in; subtraction is done by the caller inverting b and setting cin.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i + {{(WIDTH-1){1'b0}}, cin_i};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide sharing one adder.
module muldiv_iter
  import osiris_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_EX,
  input  logic [2:0]       i_op_EX,
  input  logic [WIDTH-1:0] i_rd1_EX,
  input  logic [WIDTH-1:0] i_rd2_EX,
  input  logic             i_flush_EX,
  output logic             o_ready_EX,
  output logic             o_valid_EX,
  output logic [WIDTH-1:0] o_result_EX
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_n(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  md_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic                 rneg_q;
  logic [WIDTH-1:0]     addend_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_d;

  logic [WIDTH:0]       add_a, add_b, add_sum;
  logic                 add_cin;

  logic                 sgn_a, sgn_b, div_zero, div_ovf, special;
  logic [WIDTH-1:0]     mag_a, mag_b, special_res;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;

  // Accept-time decode: signedness, magnitudes and the one-edge special cases.
  always_comb begin
    sgn_a    = i_rd1_EX[WIDTH-1] & ((i_op_EX == OP_MULH) | (i_op_EX == OP_MULHSU) |
                                    (i_op_EX == OP_DIV)  | (i_op_EX == OP_REM));
    sgn_b    = i_rd2_EX[WIDTH-1] & ((i_op_EX == OP_MULH) | (i_op_EX == OP_DIV) |
                                    (i_op_EX == OP_REM));
    mag_a    = sgn_a ? neg_n(i_rd1_EX) : i_rd1_EX;
    mag_b    = sgn_b ? neg_n(i_rd2_EX) : i_rd2_EX;
    div_zero = i_op_EX[2] & (i_rd2_EX == '0);
    div_ovf  = ((i_op_EX == OP_DIV) | (i_op_EX == OP_REM)) &
               (i_rd1_EX == MIN_NEG) & (i_rd2_EX == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = i_op_EX[1] ? i_rd1_EX : '1;
    else          special_res = i_op_EX[1] ? '0 : i_rd1_EX;
  end

  // Divide: trial-subtract divisor from {rem, next dividend bit}. Multiply: add multiplicand to high half.
  always_comb begin
    if (op_q[2]) begin
      add_a   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      add_b   = ~{1'b0, addend_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, addend_q};
      add_cin = 1'b0;
    end
  end

  adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum)
  );

  always_comb begin
    if (op_q[2]) begin
      if (add_sum[WIDTH]) prod_d = {add_a[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      else                prod_d = {add_sum[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      if (prod_q[0]) prod_d = {add_sum, prod_q[WIDTH-1:1]};
      else           prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
    end
  end

  // Finalisation: restore signs, then pick the half or quotient/remainder the op asks for.
  always_comb begin
    prod_s = neg_q  ? neg_w(prod_q) : prod_q;
    quo_s  = neg_q  ? neg_n(prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
    rem_s  = rneg_q ? neg_n(prod_q[2*WIDTH-1:WIDTH]) : prod_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                       result_d = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result_d = quo_s;
      default:                      result_d = rem_s;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (i_flush_EX) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start_EX) begin
            op_q     <= i_op_EX;
            neg_q    <= sgn_a ^ sgn_b;
            rneg_q   <= sgn_a;
            addend_q <= i_op_EX[2] ? mag_b : mag_a;
            prod_q   <= {{WIDTH{1'b0}}, (i_op_EX[2] ? mag_a : mag_b)};
            cnt_q    <= '0;
            if (special) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_q <= result_d;
            state_q  <= DONE;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready_EX  = (state_q != CALC);
  assign o_valid_EX  = (state_q == DONE);
  assign o_result_EX = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed-vector bench for muldiv_iter at WIDTH=32: results, latency, specials, flush, back-to-back, reset.
module tb_muldiv_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rd1, rd2;
  logic        flush;
  logic        ready, valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  muldiv_iter #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start_EX  (start),
    .i_op_EX     (op),
    .i_rd1_EX    (rd1),
    .i_rd2_EX    (rd2),
    .i_flush_EX  (flush),
    .o_ready_EX  (ready),
    .o_valid_EX  (valid),
    .o_result_EX (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; return the result, latency in edges (accept edge = 1) and the edge stamp of valid.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output int lat, output int vedge);
    @(negedge clk);
    start = 1'b1; op = o; rd1 = a; rd2 = b;
    @(posedge clk); #1;
    start = 1'b0; rd1 = a ^ 32'hDEAD_BEEF; rd2 = ~b;
    lat = 1;
    while (!valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    vedge = edges;
  endtask

  // Watch n cycles and report whether valid was ever seen.
  task automatic watch_quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
  endtask

  logic [31:0] r, prev;
  int          lat, ve1, ve2;
  logic        seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; rd1 = '0; rd2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, r, lat, ve1);
    chk("mul_7x-3", r, 32'hFFFF_FFEB);
    chk("mul_latency", 32'(lat), 32'd34);
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'b0, valid}, 32'd0);
    chk("ready_after_done", {31'b0, ready}, 32'd1);

    run(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ve1);
    chk("mulh", r, 32'h0000_0000);
    run(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ve1);
    chk("mulhu", r, 32'h7FFF_FFFF);
    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ve1);
    chk("mulhsu", r, 32'h8000_0000);
    chk("mulhsu_latency", 32'(lat), 32'd34);

    run(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, ve1);
    chk("div_-7/2", r, 32'hFFFF_FFFD);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, ve1);
    chk("rem_-7/2", r, 32'hFFFF_FFFF);
    run(3'b101, 32'd100, 32'd7, r, lat, ve1);
    chk("divu_100/7", r, 32'd14);
    run(3'b111, 32'd100, 32'd7, r, lat, ve1);
    chk("remu_100/7", r, 32'd2);
    chk("remu_latency", 32'(lat), 32'd34);

    run(3'b100, 32'h1234_5678, 32'd0, r, lat, ve1);
    chk("div_by_0", r, 32'hFFFF_FFFF);
    chk("div_by_0_latency", 32'(lat), 32'd1);
    run(3'b111, 32'd5, 32'd0, r, lat, ve1);
    chk("remu_by_0", r, 32'd5);
    chk("remu_by_0_latency", 32'(lat), 32'd1);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ve1);
    chk("div_ovf", r, 32'h8000_0000);
    chk("div_ovf_latency", 32'(lat), 32'd1);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ve1);
    chk("rem_ovf", r, 32'd0);
    chk("rem_ovf_latency", 32'(lat), 32'd1);

    // Flush after the 9th iteration edge, i.e. during iteration 10.
    prev = result;
    @(negedge clk);
    start = 1'b1; op = 3'b000; rd1 = 32'd9; rd2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready}, 32'd1);
    chk("flush_valid", {31'b0, valid}, 32'd0);
    chk("flush_result_held", result, prev);
    watch_quiet(40, seen);
    chk("flush_no_valid", {31'b0, seen}, 32'd0);

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; rd1 = 32'd3; rd2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", {31'b0, ready}, 32'd1);
    watch_quiet(40, seen);
    chk("flush_start_no_valid", {31'b0, seen}, 32'd0);
    chk("flush_start_result", result, prev);

    run(3'b101, 32'd1000, 32'd10, r, lat, ve1);
    chk("b2b_divu", r, 32'd100);
    run(3'b000, 32'd6, 32'd7, r, lat, ve2);
    chk("b2b_mul", r, 32'd42);
    chk("b2b_spacing", 32'(ve2 - ve1), 32'd34);

    @(negedge clk);
    start = 1'b1; op = 3'b000; rd1 = 32'd11; rd2 = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    watch_quiet(40, seen);
    chk("midrst_no_valid", {31'b0, seen}, 32'd0);

    run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, ve1);
    chk("mul_after_rst", r, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
